// File: rtl/qed_tracker_pkg.sv
// Shared types and constants for the QED commit tracker slice.
package qed_tracker_pkg;

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_CHECK = 2'd1,
        S_SAT   = 2'd2
    } sif_state_t;

    localparam int          CNT_W_DEFAULT = 8;
    localparam logic [31:0] QED_NOP       = 32'h13;

endpackage

// File: rtl/qed_sat_counter.sv
// Saturating up-counter with synchronous clear; exposes its next value so the
// parent can make decisions on the post-update count in the same cycle.
module qed_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic [W-1:0] count_next,
    output logic         at_max
);

    assign at_max = (count == {W{1'b1}});

    always_comb begin
        count_next = count;
        if (clear)
            count_next = '0;
        else if (inc && !at_max)
            count_next = count + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else
            count <= count_next;
    end

endmodule

// File: rtl/qed_commit_tracker.sv
// Tracks original/duplicate commits for SQED, marks the commit point T_C and
// qualifies later consistency checks. Optional: QED_DUP_ORDER_CHECK_EN adds order_err.
module qed_commit_tracker
    import qed_tracker_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             retire_valid,
    input  logic             retire_dup,
    input  logic             retire_ignore,
    input  logic             sif_trigger,
    output logic             sif_commit,
    output logic             sif_commit_pulsed,
    output logic             qed_check_valid,
    output logic [CNT_W-1:0] qed_num_orig,
    output logic [CNT_W-1:0] qed_num_dup,
    output logic [1:0]       sif_state,
`ifdef QED_DUP_ORDER_CHECK_EN
    output logic             order_err,
`endif
    output logic             cnt_sat
);

    sif_state_t       state;
    logic             counted;
    logic             fire;
    logic             in_check;
    logic             in_sat;
    logic             inc_orig;
    logic             inc_dup;
    logic             overflow;
    logic             orig_at_max;
    logic             dup_at_max;
    logic             order_err_next;
    logic [CNT_W-1:0] orig_next;
    logic [CNT_W-1:0] dup_next;

    // Anything that is neither S_CHECK nor S_SAT behaves as S_WAIT, so the
    // unused encoding 3 recovers through the wait path.
    always_comb begin
        in_check = (state == S_CHECK);
        in_sat   = (state == S_SAT);
        counted  = retire_valid && !retire_ignore;
        fire     = !in_check && !in_sat && sif_commit && sif_trigger;
        inc_orig = counted && !retire_dup && !fire && !in_sat;
        inc_dup  = counted &&  retire_dup && !fire && !in_sat;
        overflow = (inc_orig && orig_at_max) || (inc_dup && dup_at_max);
    end

    assign sif_commit_pulsed = fire;
    assign sif_state         = state;

    qed_sat_counter #(.W(CNT_W)) u_orig_cnt (
        .clk        (clk),
        .rst        (rst),
        .clear      (fire),
        .inc        (inc_orig),
        .count      (qed_num_orig),
        .count_next (orig_next),
        .at_max     (orig_at_max)
    );

    qed_sat_counter #(.W(CNT_W)) u_dup_cnt (
        .clk        (clk),
        .rst        (rst),
        .clear      (fire),
        .inc        (inc_dup),
        .count      (qed_num_dup),
        .count_next (dup_next),
        .at_max     (dup_at_max)
    );

`ifdef QED_DUP_ORDER_CHECK_EN
    assign order_err_next = order_err || (in_check && inc_dup && (dup_next > orig_next));
`else
    assign order_err_next = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_WAIT;
            sif_commit      <= 1'b0;
            qed_check_valid <= 1'b0;
            cnt_sat         <= 1'b0;
`ifdef QED_DUP_ORDER_CHECK_EN
            order_err       <= 1'b0;
`endif
        end else if (overflow || in_sat) begin
            state           <= S_SAT;
            cnt_sat         <= 1'b1;
            sif_commit      <= 1'b0;
            qed_check_valid <= 1'b0;
        end else begin
            if (fire || in_check)
                state <= S_CHECK;
            else
                state <= S_WAIT;
            if (inc_orig || inc_dup)
                sif_commit <= (orig_next == dup_next);
            // Check validity is judged on the counts as they will be after this edge.
            qed_check_valid <= in_check && (orig_next != '0) && !order_err_next;
`ifdef QED_DUP_ORDER_CHECK_EN
            order_err <= order_err_next;
`endif
        end
    end

endmodule

// File: tb/tb_qed_commit_tracker.sv
// Directed self-checking bench for qed_commit_tracker with a 3-bit counter build.
module tb_qed_commit_tracker;

    localparam int TB_W = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            retire_valid = 1'b0;
    logic            retire_dup = 1'b0;
    logic            retire_ignore = 1'b0;
    logic            sif_trigger = 1'b0;
    logic            sif_commit;
    logic            sif_commit_pulsed;
    logic            qed_check_valid;
    logic [TB_W-1:0] qed_num_orig;
    logic [TB_W-1:0] qed_num_dup;
    logic [1:0]      sif_state;
    logic            cnt_sat;
`ifdef QED_DUP_ORDER_CHECK_EN
    logic            order_err;
`endif

    int vectors = 0;
    int miscompares = 0;

    qed_commit_tracker #(.CNT_W(TB_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .retire_valid      (retire_valid),
        .retire_dup        (retire_dup),
        .retire_ignore     (retire_ignore),
        .sif_trigger       (sif_trigger),
        .sif_commit        (sif_commit),
        .sif_commit_pulsed (sif_commit_pulsed),
        .qed_check_valid   (qed_check_valid),
        .qed_num_orig      (qed_num_orig),
        .qed_num_dup       (qed_num_dup),
        .sif_state         (sif_state),
`ifdef QED_DUP_ORDER_CHECK_EN
        .order_err         (order_err),
`endif
        .cnt_sat           (cnt_sat)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

    // Drive one cycle of inputs, clock it in, then return inputs to idle.
    task automatic applyStimulus(input logic v, input logic d, input logic ign, input logic trig);
        retire_valid  = v;
        retire_dup    = d;
        retire_ignore = ign;
        sif_trigger   = trig;
        @(posedge clk);
        #1;
        retire_valid  = 1'b0;
        retire_dup    = 1'b0;
        retire_ignore = 1'b0;
        sif_trigger   = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        vectors++;
        if ({sif_commit, sif_commit_pulsed, qed_check_valid, cnt_sat} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got %b expected 0000",
                     {sif_commit, sif_commit_pulsed, qed_check_valid, cnt_sat});
        end
        vectors++;
        if (qed_num_orig !== 3'd0 || qed_num_dup !== 3'd0 || sif_state !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_counts: got orig=%0d dup=%0d state=%0d expected 0/0/0",
                     qed_num_orig, qed_num_dup, sif_state);
        end
    endtask

    task automatic test_commit_sequence();
        logic [3:0] pattern_dup;
        logic [3:0] exp_commit;
        pattern_dup = 4'b1010;
        exp_commit  = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, pattern_dup[i], 1'b0, 1'b0);
            vectors++;
            if (sif_commit !== exp_commit[i]) begin
                miscompares++;
                $display("[TB] FAIL commit_step%0d: got %b expected %b", i, sif_commit, exp_commit[i]);
            end
        end
        vectors++;
        if (qed_num_orig !== 3'd2 || qed_num_dup !== 3'd2) begin
            miscompares++;
            $display("[TB] FAIL commit_counts: got %0d/%0d expected 2/2", qed_num_orig, qed_num_dup);
        end
    endtask

    task automatic test_ignore();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, i[0], 1'b1, 1'b0);
            vectors++;
            if (qed_num_orig !== 3'd2 || qed_num_dup !== 3'd2 || sif_commit !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL ignore_step%0d: got %0d/%0d commit=%b expected 2/2 commit=1",
                         i, qed_num_orig, qed_num_dup, sif_commit);
            end
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (qed_num_orig !== 3'd2 || qed_num_dup !== 3'd2 || sif_state !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL invalid_noop: got %0d/%0d state=%0d expected 2/2 state=0",
                     qed_num_orig, qed_num_dup, sif_state);
        end
    endtask

    task automatic test_trigger();
        retire_valid = 1'b1;
        retire_dup   = 1'b0;
        sif_trigger  = 1'b1;
        #1;
        vectors++;
        if (sif_commit_pulsed !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL pulse_high: got %b expected 1", sif_commit_pulsed);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (qed_num_orig !== 3'd0 || qed_num_dup !== 3'd0 || sif_state !== 2'd1) begin
            miscompares++;
            $display("[TB] FAIL trigger_clear: got %0d/%0d state=%0d expected 0/0 state=1",
                     qed_num_orig, qed_num_dup, sif_state);
        end
        vectors++;
        if (sif_commit_pulsed !== 1'b0 || qed_check_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL pulse_one_cycle: got pulsed=%b valid=%b expected 0/0",
                     sif_commit_pulsed, qed_check_valid);
        end
        retire_valid = 1'b0;
        sif_trigger  = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (qed_check_valid !== 1'b0 || sif_commit !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL idle_in_check: got valid=%b commit=%b expected 0/1",
                     qed_check_valid, sif_commit);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (qed_check_valid !== 1'b1 || qed_num_orig !== 3'd1 || sif_commit !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL first_orig_valid: got valid=%b orig=%0d commit=%b expected 1/1/0",
                     qed_check_valid, qed_num_orig, sif_commit);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        sif_trigger = 1'b1;
        #1;
        vectors++;
        if (sif_commit !== 1'b1 || sif_commit_pulsed !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL no_repulse: got commit=%b pulsed=%b expected 1/0",
                     sif_commit, sif_commit_pulsed);
        end
        @(posedge clk);
        #1;
        sif_trigger = 1'b0;
        vectors++;
        if (sif_state !== 2'd1 || qed_num_orig !== 3'd1 || qed_num_dup !== 3'd1) begin
            miscompares++;
            $display("[TB] FAIL stay_check: got state=%0d %0d/%0d expected 1 1/1",
                     sif_state, qed_num_orig, qed_num_dup);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 7; i++)
            applyStimulus(1'b1, i[0], 1'b0, 1'b0);
        vectors++;
        if (qed_num_orig !== 3'd5 || qed_num_dup !== 3'd4 || qed_check_valid !== 1'b1 || sif_state !== 2'd1) begin
            miscompares++;
            $display("[TB] FAIL pre_reset: got %0d/%0d valid=%b state=%0d expected 5/4 1 1",
                     qed_num_orig, qed_num_dup, qed_check_valid, sif_state);
        end
        doReset();
        vectors++;
        if ({sif_commit, qed_check_valid, cnt_sat, qed_num_orig, qed_num_dup, sif_state} !== '0) begin
            miscompares++;
            $display("[TB] FAIL mid_reset: got commit=%b valid=%b sat=%b %0d/%0d state=%0d expected all 0",
                     sif_commit, qed_check_valid, cnt_sat, qed_num_orig, qed_num_dup, sif_state);
        end
    endtask

    task automatic test_saturation();
        doReset();
        for (int i = 0; i < 7; i++)
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (qed_num_orig !== 3'd7 || cnt_sat !== 1'b0 || sif_state !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL at_max: got orig=%0d sat=%b state=%0d expected 7/0/0",
                     qed_num_orig, cnt_sat, sif_state);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (qed_num_orig !== 3'd7 || cnt_sat !== 1'b1 || sif_state !== 2'd2) begin
            miscompares++;
            $display("[TB] FAIL saturate: got orig=%0d sat=%b state=%0d expected 7/1/2",
                     qed_num_orig, cnt_sat, sif_state);
        end
        vectors++;
        if (sif_commit !== 1'b0 || qed_check_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL sat_outputs: got commit=%b valid=%b expected 0/0",
                     sif_commit, qed_check_valid);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (qed_num_dup !== 3'd0 || sif_state !== 2'd2 || cnt_sat !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL sat_terminal: got dup=%0d state=%0d sat=%b expected 0/2/1",
                     qed_num_dup, sif_state, cnt_sat);
        end
    endtask

    task automatic test_order();
        logic exp_valid;
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (qed_num_orig !== 3'd0 || qed_num_dup !== 3'd1 || qed_check_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL dup_first: got %0d/%0d valid=%b expected 0/1 valid=0",
                     qed_num_orig, qed_num_dup, qed_check_valid);
        end
`ifdef QED_DUP_ORDER_CHECK_EN
        vectors++;
        if (order_err !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL order_err_set: got %b expected 1", order_err);
        end
        exp_valid = 1'b0;
`else
        exp_valid = 1'b1;
`endif
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (qed_num_orig !== 3'd2 || qed_check_valid !== exp_valid) begin
            miscompares++;
            $display("[TB] FAIL order_valid: got orig=%0d valid=%b expected 2 valid=%b",
                     qed_num_orig, qed_check_valid, exp_valid);
        end
`ifdef QED_DUP_ORDER_CHECK_EN
        vectors++;
        if (order_err !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL order_err_sticky: got %b expected 1", order_err);
        end
`endif
    endtask

    initial begin
        $display("[TB] starting qed_commit_tracker bench");
        test_reset();
        test_commit_sequence();
        test_ignore();
        test_trigger();
        test_reset_mid();
        test_saturation();
        test_order();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/qed_commit_tracker.md
Name: qed_commit_tracker

Overview:
- Sits inside the SQED-instrumented core (`dut`), directly upstream of the formal property module.
- Consumes per-cycle retire events from the core writeback stage and counts committed original and duplicate instructions.
- Produces the commit-tracking signals the property module binds to: `sif_commit`, `sif_commit_pulsed`, `qed_check_valid`, `qed_num_orig`, `qed_num_dup`, `sif_state`.
- Marks the QED-consistent commit point T_C and then the cycles where a consistency check is meaningful.

Parameters:
- CNT_W, 8, width of the original and duplicate retire counters.
- CNT_MAX, 2**CNT_W-1, saturation value of either counter.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous, active-high reset
- retire_valid  input  1  one instruction retires this cycle
- retire_dup  input  1  retiring instruction belongs to the duplicate half (dest/src regs 16-31, mem 16-31)
- retire_ignore  input  1  retiring instruction is a QED-excluded NOP (addi x0,x0,0 / 'h13); not counted
- sif_trigger  input  1  free (unconstrained) input selecting the cycle T_C
- sif_commit  output  1  orig and dup counts equal after a counted retire
- sif_commit_pulsed  output  1  one-cycle pulse marking T_C
- qed_check_valid  output  1  at least one original retired since T_C
- qed_num_orig  output  CNT_W  original retire count
- qed_num_dup  output  CNT_W  duplicate retire count
- sif_state  output  2  FSM state encoding
- cnt_sat  output  1  sticky; a counter reached CNT_MAX

Behaviour:
- Reset values: all outputs 0; `sif_state` = S_WAIT (0). Reset mid-operation clears the counters, the FSM and the sticky flags on the next edge.
- Counted event: `retire_valid && !retire_ignore`.
  - With `retire_dup` = 0: `qed_num_orig` += 1.
  - With `retire_dup` = 1: `qed_num_dup` += 1.
  - At most one event per cycle; registered, 1-cycle latency.
- `sif_commit` (registered):
  - Set on the edge after a counted event leaves `num_orig_next == num_dup_next`.
  - Cleared on the edge after a counted event leaves them unequal.
  - Holds its value in cycles with no counted event.
  - Forced 0 while `cnt_sat` = 1.
- FSM:
  - S_WAIT (0): if `sif_commit && sif_trigger` →
    - pulse `sif_commit_pulsed` for exactly one cycle (combinational on the state/inputs, aligned with `sif_commit`);
    - clear both counters on that edge (a simultaneous counted event is dropped);
    - go to S_CHECK.
  - S_CHECK (1): `qed_check_valid` = (`qed_num_orig` != 0), registered with the counters. `sif_commit_pulsed` never reasserts. Go to S_SAT when either counter would exceed CNT_MAX.
  - S_SAT (2): counters hold at CNT_MAX / current value; `cnt_sat` = 1; `qed_check_valid` = 0; terminal until `rst`.
  - S_WAIT also goes to S_SAT on saturation.
  - Encoding 3 is unreachable; it decodes to S_WAIT.
- Wrap-around: counters never wrap. An increment at CNT_MAX saturates and enters S_SAT.
- A `retire_ignore` event with `retire_valid` = 0 is a no-op. `retire_dup` is ignored when `retire_valid` = 0.

Optional Feature:
- Macro: `QED_DUP_ORDER_CHECK_EN`.
- When defined:
  - Adds output `order_err` (1 bit, sticky, reset 0).
  - `order_err` is set on the edge after a counted dup retire makes `qed_num_dup > qed_num_orig` in S_CHECK.
  - While `order_err` = 1, `qed_check_valid` is forced 0.
- When undefined: port absent, no ordering check, behaviour otherwise identical.

Decomposition:
- Package `qed_tracker_pkg`:
  - state typedef `sif_state_t` {S_WAIT=0, S_CHECK=1, S_SAT=2};
  - default CNT_W;
  - NOP encoding constant QED_NOP = 32'h13.
- One sub-module, `qed_sat_counter`:
  - CNT_W-bit saturating up-counter with sync clear;
  - outputs `at_max`;
  - instantiated twice (orig, dup).

Test Plan:
- Reset, then orig, dup, orig, dup retires → after the 2nd and 4th events `sif_commit` = 1; after the 1st and 3rd it is 0; counts 2/2.
- `sif_commit` = 1 with `sif_trigger` = 1 in S_WAIT → `sif_commit_pulsed` high for 1 cycle; counts 0/0; `sif_state` = 1; `qed_check_valid` = 0 until the next orig retire, then 1.
- `retire_ignore` = 1 on 3 consecutive retires → counts unchanged; `sif_commit` unchanged.
- CNT_W = 3: 8 orig retires → `qed_num_orig` stays 7; `cnt_sat` = 1; `sif_state` = 2; `sif_commit` = 0; `qed_check_valid` = 0.
- Assert `rst` in S_CHECK with counts 5/4 → next cycle all outputs 0, `sif_state` = 0.
- With `QED_DUP_ORDER_CHECK_EN`: in S_CHECK, dup retire with counts 0/0 → `order_err` = 1 and `qed_check_valid` = 0 on all later cycles.
